// File: rtl/mul_sched_pkg.sv
// ---------------------------------------------------------------------------
// mul_sched_pkg
// Shared definitions for the shared-multiplier scheduler:
//   - state_t     : scheduler FSM encoding (IDLE / RUN / DONE)
//   - clog2_min1  : ceil(log2(n)) with a floor of 1, used for index widths
//   - DEF_WIDTH / DEF_NREQ : default operand width and requester count
// ---------------------------------------------------------------------------
package mul_sched_pkg;

  localparam int DEF_WIDTH = 8;
  localparam int DEF_NREQ  = 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Width of an index able to address n items; never less than one bit so
  // that single-entry ranges still produce a legal vector.
  function automatic int clog2_min1(input int n);
    int w;
    w = 1;
    while ((1 << w) < n) w++;
    return w;
  endfunction

endpackage

// File: rtl/mul_seq_core.sv
// ---------------------------------------------------------------------------
// mul_seq_core
// Iterative signed WIDTH x WIDTH shift-add multiplier (sign/magnitude).
// A start pulse captures the operands; exactly WIDTH add/shift steps follow
// and done pulses for one cycle WIDTH+1 cycles after start, with product
// updated in the same cycle. product holds its value until the next job.
//
// Ports:
//   CLK, RST  clock, asynchronous active-high reset
//   start     capture a/b and begin a job (ignored while a job is running
//             only by construction of the caller)
//   a, b      signed operands, WIDTH bits each
//   done      one-cycle completion pulse
//   product   signed 2*WIDTH-bit result, held between jobs
// ---------------------------------------------------------------------------
module mul_seq_core
  import mul_sched_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 start,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 done,
  output logic [2*WIDTH-1:0]   product
);

  localparam int CW = clog2_min1(WIDTH);

  // |x| needs WIDTH+1 bits during negation so that -2^(WIDTH-1) does not
  // wrap back onto itself.
  function automatic logic [WIDTH:0] magnitude(input logic [WIDTH-1:0] x);
    logic [WIDTH:0] ext;
    ext = {x[WIDTH-1], x};
    return x[WIDTH-1] ? -ext : ext;
  endfunction

  logic [WIDTH:0]       mag_a;
  logic [WIDTH:0]       mag_b;
  logic [2*WIDTH-1:0]   mcand;
  logic [WIDTH:0]       mplier;
  logic [2*WIDTH-1:0]   acc;
  logic [2*WIDTH-1:0]   acc_next;
  logic [CW-1:0]        cnt;
  logic                 neg;
  logic                 running;

  assign mag_a = magnitude(a);
  assign mag_b = magnitude(b);

  // NOTE: every signal written in always_comb gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    acc_next = acc;
    if (mplier[0]) acc_next = acc + (mcand << cnt);
  end

  // NOTE: state registers use non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      mcand   <= '0;
      mplier  <= '0;
      acc     <= '0;
      cnt     <= '0;
      neg     <= 1'b0;
      running <= 1'b0;
      done    <= 1'b0;
      product <= '0;
    end else begin
      done <= 1'b0;
      if (start) begin
        mcand   <= {{(WIDTH-1){1'b0}}, mag_a};
        mplier  <= mag_b;
        acc     <= '0;
        cnt     <= '0;
        neg     <= a[WIDTH-1] ^ b[WIDTH-1];
        running <= 1'b1;
      end else if (running) begin
        acc    <= acc_next;
        mplier <= mplier >> 1;
        cnt    <= cnt + 1'b1;
        if (cnt == CW'(WIDTH-1)) begin
          running <= 1'b0;
          done    <= 1'b1;
          // Zero magnitude negates to zero, so no negative-zero case exists.
          product <= neg ? -acc_next : acc_next;
        end
      end
    end
  end

endmodule

// File: rtl/mul_share_sched.sv
// ---------------------------------------------------------------------------
// mul_share_sched
// Shares one mul_seq_core among NREQ requesters. A round-robin arbiter picks
// one valid requester per IDLE cycle, the job runs for WIDTH cycles, and the
// result is returned to the owner in DONE. Latency from req_ready to
// rsp_valid is WIDTH+1 cycles; one job completes every WIDTH+2 cycles.
//
// Ports:
//   CLK, RST     clock, asynchronous active-high reset
//   req_valid    per-requester operand valid (held until req_ready)
//   req_a/req_b  packed signed operands, slice i belongs to requester i
//   req_ready    one-hot accept, combinational, only in IDLE
//   rsp_valid    one-hot result pulse to the job owner
//   rsp_product  signed 2*WIDTH-bit product, held between pulses
//   busy         high while in RUN or DONE
//   grant_id     index of the current or last owner
// ---------------------------------------------------------------------------
module mul_share_sched
  import mul_sched_pkg::*;
#(
  parameter  int NREQ  = DEF_NREQ,
  parameter  int WIDTH = DEF_WIDTH,
  localparam int GW    = clog2_min1(NREQ)
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic [NREQ-1:0]         req_valid,
  input  logic [NREQ*WIDTH-1:0]   req_a,
  input  logic [NREQ*WIDTH-1:0]   req_b,
  output logic [NREQ-1:0]         req_ready,
  output logic [NREQ-1:0]         rsp_valid,
  output logic [2*WIDTH-1:0]      rsp_product,
  output logic                    busy,
  output logic [GW-1:0]           grant_id
);

  localparam int              CW      = clog2_min1(WIDTH);
  localparam logic [NREQ-1:0] ONE_HOT = NREQ'(1);

  state_t          state;
  logic [GW-1:0]   rr_ptr;
  logic [CW-1:0]   cnt;
  logic            found;
  logic [GW-1:0]   pick;
  logic            grant_ok;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic            core_done;

  // Round-robin search: first valid requester at or above rr_ptr, wrapping.
  always_comb begin
    int j;
    logic [GW-1:0] idx;
    found = 1'b0;
    pick  = '0;
    j     = 0;
    idx   = '0;
    for (int k = 0; k < NREQ; k++) begin
      j = int'(rr_ptr) + k;
      if (j >= NREQ) j = j - NREQ;
      idx = GW'(j);
      if (!found && req_valid[idx]) begin
        found = 1'b1;
        pick  = idx;
      end
    end
  end

  // RST gating keeps req_ready at its reset value while reset is held,
  // even though the FSM already sits in IDLE.
  assign grant_ok  = (state == IDLE) && found && !RST;
  assign req_ready = grant_ok ? (ONE_HOT << pick) : '0;

  assign op_a = req_a[pick*WIDTH +: WIDTH];
  assign op_b = req_b[pick*WIDTH +: WIDTH];

  mul_seq_core #(
    .WIDTH (WIDTH)
  ) u_core (
    .CLK     (CLK),
    .RST     (RST),
    .start   (grant_ok),
    .a       (op_a),
    .b       (op_b),
    .done    (core_done),
    .product (rsp_product)
  );

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state    <= IDLE;
      rr_ptr   <= '0;
      cnt      <= '0;
      grant_id <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (grant_ok) begin
            grant_id <= pick;
            rr_ptr   <= (pick == GW'(NREQ-1)) ? '0 : pick + 1'b1;
            cnt      <= '0;
            state    <= RUN;
          end
        end
        RUN: begin
          cnt <= cnt + 1'b1;
          if (cnt == CW'(WIDTH-1)) state <= DONE;
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // The core finishes in lock-step with DONE; requiring both keeps the
  // response tied to a job the scheduler actually granted.
  assign rsp_valid = ((state == DONE) && core_done) ? (ONE_HOT << grant_id) : '0;
  assign busy      = (state != IDLE);

endmodule

// File: tb/tb_mul_share_sched.sv
// ---------------------------------------------------------------------------
// tb_mul_share_sched
// Scoreboard bench for mul_share_sched (NREQ=2, WIDTH=8). Each grant seen on
// req_ready pushes the expected owner, product and grant cycle; each
// rsp_valid pops and compares routing, product and latency.
// ---------------------------------------------------------------------------
module tb_mul_share_sched;

  localparam int NREQ  = 2;
  localparam int WIDTH = 8;
  localparam int LAT   = WIDTH + 1;
  localparam int SLOT  = WIDTH + 2;

  typedef struct {
    int          id;
    logic [15:0] prod;
    int          cyc;
  } exp_t;

  logic                    CLK = 1'b0;
  logic                    RST = 1'b1;
  logic [NREQ-1:0]         req_valid;
  logic [NREQ*WIDTH-1:0]   req_a;
  logic [NREQ*WIDTH-1:0]   req_b;
  logic [NREQ-1:0]         req_ready;
  logic [NREQ-1:0]         rsp_valid;
  logic [2*WIDTH-1:0]      rsp_product;
  logic                    busy;
  logic [0:0]              grant_id;

  logic                    v    [NREQ];
  logic signed [WIDTH-1:0] a_op [NREQ];
  logic signed [WIDTH-1:0] b_op [NREQ];

  int          n_checks = 0;
  int          n_errors = 0;
  int          cyc = 0;
  exp_t        exp_q[$];
  int          glog_id[$];
  int          glog_cyc[$];
  logic [15:0] last_prod = '0;

  mul_share_sched #(
    .NREQ  (NREQ),
    .WIDTH (WIDTH)
  ) dut (
    .CLK         (CLK),
    .RST         (RST),
    .req_valid   (req_valid),
    .req_a       (req_a),
    .req_b       (req_b),
    .req_ready   (req_ready),
    .rsp_valid   (rsp_valid),
    .rsp_product (rsp_product),
    .busy        (busy),
    .grant_id    (grant_id)
  );

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  always_comb begin
    for (int i = 0; i < NREQ; i++) begin
      req_valid[i]                = v[i];
      req_a[i*WIDTH +: WIDTH]     = a_op[i];
      req_b[i*WIDTH +: WIDTH]     = b_op[i];
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Scoreboard monitor, sampled on the falling edge.
  always @(negedge CLK) begin
    if (!RST) begin
      if (req_ready != '0) begin
        int   id;
        int   p;
        exp_t e;
        id = 0;
        for (int i = 0; i < NREQ; i++) if (req_ready[i]) id = i;
        check("ready_onehot", $countones(req_ready), 1);
        check("ready_in_idle", busy, 0);
        check("ready_has_valid", req_ready & ~req_valid, 0);
        p      = int'(a_op[id]) * int'(b_op[id]);
        e.id   = id;
        e.prod = p[15:0];
        e.cyc  = cyc;
        exp_q.push_back(e);
        glog_id.push_back(id);
        glog_cyc.push_back(cyc);
      end
      if (rsp_valid != '0) begin
        if (exp_q.size() == 0) begin
          check("rsp_unexpected", rsp_valid, 0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check("rsp_route", rsp_valid, 32'(1) << e.id);
          check("rsp_product", rsp_product, e.prod);
          check("rsp_latency", cyc - e.cyc, LAT);
          check("rsp_busy", busy, 1);
          last_prod = e.prod;
        end
      end
    end
  end

  // Raise valid, wait (bounded) for the accept, drop valid after the edge.
  task automatic send(input int i, input logic signed [WIDTH-1:0] a,
                      input logic signed [WIDTH-1:0] b, output int waited);
    a_op[i] = a;
    b_op[i] = b;
    v[i]    = 1'b1;
    waited  = 0;
    forever begin
      @(negedge CLK);
      if (req_ready[i]) break;
      waited++;
      if (waited > 100) begin
        check("send_timeout", waited, 0);
        v[i] = 1'b0;
        return;
      end
    end
    @(posedge CLK);
    #1;
    v[i] = 1'b0;
  endtask

  task automatic drain();
    int k;
    k = 0;
    while (exp_q.size() != 0 && k < 200) begin
      @(negedge CLK);
      k++;
    end
    check("drain", exp_q.size(), 0);
    @(posedge CLK);
    #1;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int w0, w1;
    logic signed [WIDTH-1:0] ca [4];
    logic signed [WIDTH-1:0] cb [4];
    logic [15:0]             cp [4];

    ca[0] = -8'sd128; cb[0] = -8'sd128; cp[0] = 16'h4000;
    ca[1] = -8'sd128; cb[1] =  8'sd127; cp[1] = 16'hC080;
    ca[2] = -8'sd1;   cb[2] =  8'sd1;   cp[2] = 16'hFFFF;
    ca[3] =  8'sd0;   cb[3] = -8'sd5;   cp[3] = 16'h0000;

    // Both requesters valid from reset release.
    v[0] = 1'b1; a_op[0] = 8'sd3;  b_op[0] = 8'sd5;
    v[1] = 1'b1; a_op[1] = -8'sd4; b_op[1] = 8'sd9;
    #1;
    check("rst_req_ready", req_ready, 0);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_rsp_product", rsp_product, 0);
    check("rst_busy", busy, 0);
    check("rst_grant_id", grant_id, 0);
    repeat (2) @(posedge CLK);
    #1;
    RST = 1'b0;

    // Contention: grants alternate 0,1,0,1, one slot apart.
    fork
      begin
        send(0, 8'sd3, 8'sd5, w0);
        send(0, -8'sd7, -8'sd9, w0);
      end
      begin
        send(1, -8'sd4, 8'sd9, w1);
        send(1, 8'sd100, -8'sd3, w1);
      end
    join
    drain();
    check("cont_grants", glog_id.size(), 4);
    if (glog_id.size() == 4) begin
      for (int k = 0; k < 4; k++) begin
        check("cont_order", glog_id[k], k % 2);
        if (k > 0) check("cont_spacing", glog_cyc[k] - glog_cyc[k-1], SLOT);
      end
    end

    // Single request: 7*6, busy for cycles t+1..t+9, response at t+9.
    send(0, 8'sd7, 8'sd6, w0);
    for (int k = 1; k <= LAT; k++) begin
      @(negedge CLK);
      check("single_busy", busy, 1);
      if (k == LAT) begin
        check("single_rsp_valid", rsp_valid, 2'b01);
        check("single_product", rsp_product, 16'd42);
      end
    end
    @(negedge CLK);
    check("single_busy_after", busy, 0);
    drain();

    // Signed corners.
    for (int k = 0; k < 4; k++) begin
      send(k % 2, ca[k], cb[k], w0);
      drain();
      check("corner_product", rsp_product, cp[k]);
    end

    // Fairness: req0 held across three jobs, req1 raised once.
    glog_id.delete();
    glog_cyc.delete();
    fork
      begin
        send(0, 8'sd2, 8'sd3, w0);
        send(0, 8'sd4, 8'sd5, w0);
        send(0, 8'sd6, 8'sd7, w0);
      end
      begin
        repeat (3) @(posedge CLK);
        #1;
        send(1, -8'sd3, 8'sd3, w1);
      end
    join
    drain();
    check("fair_wait_bound", (w1 <= 2 * SLOT) ? 1 : 0, 1);
    check("fair_grants", glog_id.size(), 4);
    if (glog_id.size() >= 2) check("fair_second_grant", glog_id[1], 1);

    // Reset mid-RUN: abort, outputs clear at once, pending request granted
    // in the first cycle after release.
    send(0, 8'sd50, -8'sd2, w0);
    repeat (3) @(posedge CLK);
    #2;
    RST = 1'b1;
    #1;
    check("abort_busy", busy, 0);
    check("abort_grant_id", grant_id, 0);
    check("abort_rsp_valid", rsp_valid, 0);
    check("abort_rsp_product", rsp_product, 0);
    exp_q.delete();
    last_prod = '0;
    a_op[1] = 8'sd9;
    b_op[1] = 8'sd9;
    v[1]    = 1'b1;
    repeat (3) begin
      @(negedge CLK);
      check("abort_hold_ready", req_ready, 0);
      check("abort_hold_rsp", rsp_valid, 0);
    end
    @(posedge CLK);
    #1;
    RST = 1'b0;
    @(negedge CLK);
    check("post_rst_grant", req_ready, 2'b10);
    @(posedge CLK);
    #1;
    v[1] = 1'b0;
    drain();
    check("post_rst_product", rsp_product, 16'd81);

    // Idle stability.
    for (int k = 0; k < 100; k++) begin
      @(negedge CLK);
      check("idle_ready", req_ready, 0);
      check("idle_rsp_valid", rsp_valid, 0);
      check("idle_busy", busy, 0);
      check("idle_hold_product", rsp_product, last_prod);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
